// File: rtl/sumador_saturado_pipe.sv
// rtl/sumador_saturado_pipe.sv - pipelined saturating ADC/octave mixer with offset-binary DAC output
// Optional macro SAT_COUNT_EN adds the sat_count saturation event counter.
module sumador_saturado_pipe #(
  parameter int ADC_W = 14,
  parameter int DAC_W = 12
`ifdef SAT_COUNT_EN
  , parameter int SATCNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [ADC_W-1:0]   original_in,
  input  logic [DAC_W-1:0]   octava_in,
  input  logic [1:0]         mode,
  output logic               valid_out,
  output logic [DAC_W-1:0]   salida_total,
  output logic               sat
`ifdef SAT_COUNT_EN
  , output logic [SATCNT_W-1:0] sat_count
`endif
);

  logic [DAC_W-1:0] orig_d;
  logic [DAC_W-1:0] orig_q;
  logic [DAC_W-1:0] oct_q;
  logic [1:0]       mode_q;
  logic             v1_q;

  logic signed [DAC_W:0] sum_s;
  logic signed [DAC_W:0] r_s;
  logic             sat_d;
  logic [DAC_W-1:0] clip_d;
  logic [DAC_W-1:0] out_d;

  logic             valid_q;
  logic [DAC_W-1:0] out_q;
  logic             sat_q;

  // Dropped ADC LSBs are intentionally unused.
  logic unused_adc_bits;
  assign unused_adc_bits = ^original_in;

  assign orig_d = original_in[ADC_W-1 -: DAC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      orig_q <= '0;
      oct_q  <= '0;
      mode_q <= 2'b00;
    end else begin
      v1_q <= valid_in;
      if (valid_in) begin
        orig_q <= orig_d;
        oct_q  <= octava_in;
        mode_q <= mode;
      end
    end
  end

  always_comb begin
    sum_s = $signed({orig_q[DAC_W-1], orig_q}) + $signed({oct_q[DAC_W-1], oct_q});
    case (mode_q)
      2'b00:   r_s = sum_s;
      2'b01:   r_s = $signed({orig_q[DAC_W-1], orig_q});
      2'b10:   r_s = $signed({oct_q[DAC_W-1], oct_q});
      default: r_s = sum_s >>> 1;
    endcase
    // The extra top bit disagreeing with the DAC sign bit means the result left the DAC range.
    sat_d  = r_s[DAC_W] ^ r_s[DAC_W-1];
    clip_d = sat_d ? {r_s[DAC_W], {(DAC_W-1){~r_s[DAC_W]}}} : r_s[DAC_W-1:0];
    out_d  = {~clip_d[DAC_W-1], clip_d[DAC_W-2:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= {1'b1, {(DAC_W-1){1'b0}}};
      sat_q   <= 1'b0;
    end else begin
      valid_q <= v1_q;
      if (v1_q) begin
        out_q <= out_d;
        sat_q <= sat_d;
      end
    end
  end

  assign valid_out    = valid_q;
  assign salida_total = out_q;
  assign sat          = sat_q;

`ifdef SAT_COUNT_EN
  logic [SATCNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (v1_q && sat_d && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sat_count = cnt_q;
`endif

endmodule

// File: doc/sumador_saturado_pipe.md
Name: sumador_saturado_pipe

Overview:
- Parametrised, pipelined successor to the combinational ADC/octave adder in the octaver audio path.
- Converts the two's-complement ADC sample to DAC width and mixes it with the octave-generator sample in one of four modes.
- Saturates on overflow and emits offset-binary data for the DAC.
- Has a valid handshake, fixed 2-cycle latency and a saturation flag; sits between the ADC capture/octave modules and the DAC driver.

Parameters:
- ADC_W, 14, ADC sample width, two's complement; must satisfy ADC_W >= DAC_W.
- DAC_W, 12, DAC word width; also the width of octava_in.
- SATCNT_W, 16, width of the saturation event counter (used only with SAT_COUNT_EN).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  original_in, octava_in and mode are valid this cycle.
- original_in  input  ADC_W  ADC sample, two's complement.
- octava_in  input  DAC_W  octave sample, two's complement.
- mode  input  2  mix select, sampled with valid_in: 00 sum, 01 original only, 10 octave only, 11 average.
- valid_out  output  1  salida_total and sat are valid this cycle.
- salida_total  output  DAC_W  mixed sample, offset binary, for the DAC.
- sat  output  1  the sample on salida_total was clipped.
- sat_count  output  SATCNT_W  saturation event count (present only with SAT_COUNT_EN).

Behaviour:
- Reset (rst=1 at a clock edge):
  - valid_out=0, sat=0, salida_total=2^(DAC_W-1) (mid-scale, 12'h800 at defaults).
  - Both pipeline stages are cleared, so in-flight samples are discarded.
  - There is no output for any valid_in sampled during reset.
- Stage 1 is registered only when valid_in=1; otherwise it holds its value.
  - orig_t = original_in[ADC_W-1 : ADC_W-DAC_W]. This is an arithmetic truncation of the LSBs with no rounding.
  - The stage also registers octava_in and mode.
  - v1 <= valid_in.
- Stage 2 computes a signed DAC_W+1 result r:
  - mode 00: r = orig_t + octava_in.
  - mode 01: r = orig_t.
  - mode 10: r = octava_in.
  - mode 11: r = (orig_t + octava_in) >>> 1. This is an arithmetic shift that floors toward minus infinity, and it never saturates.
- Saturation:
  - If r > 2^(DAC_W-1)-1, clip to 2^(DAC_W-1)-1 and set sat=1.
  - If r < -2^(DAC_W-1), clip to -2^(DAC_W-1) and set sat=1.
  - Otherwise sat=0.
- Output format: salida_total is the clipped value with its MSB inverted, which is offset binary (equivalent to adding 2^(DAC_W-1)).
- Latency and hold:
  - Exactly 2 cycles from valid_in to valid_out. Back-to-back valid_in gives one result per cycle, with no bubbles and no backpressure.
  - valid_out = v1 delayed one cycle.
  - When valid_out=0, salida_total and sat keep their last values so the DAC sees a stable word.
- Mode changes take effect per sample, since mode travels down the pipeline with its data.
- ADC_W == DAC_W is legal: no truncation is applied.

Optional Feature:
- Macro SAT_COUNT_EN.
  - Defined:
    - Adds port sat_count. Reset value is 0.
    - Increments by 1 on each cycle where valid_out and sat are both 1.
    - Saturates at all-ones and does not wrap.
    - Updated in the same cycle as valid_out.
  - Not defined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Positive overflow: defaults, mode 00, original_in=14'h1FFF, octava_in=12'h001. Required: valid_out high 2 cycles later, salida_total=12'hFFF, sat=1.
- Negative overflow: mode 00, original_in=14'h2000, octava_in=12'h800. Required: salida_total=12'h000, sat=1. A second case, original_in=14'h0000 with octava_in=12'h000, must give salida_total=12'h800, sat=0.
- Modes:
  - original_in=14'h1FFC (orig_t=12'h7FF), octava_in=12'h7FF, mode 11. Required: salida_total=12'hFFF, sat=0.
  - original_in=14'h3FFF (orig_t=-1), octava_in=12'h000, mode 11. Required: salida_total=12'h7FF, because -1>>>1 = -1.
  - mode 01 with octava_in=12'h7FF and original_in=14'h0004. Required: salida_total=12'h801.
  - mode 10 with octava_in=12'h7FF. Required: salida_total=12'hFFF.
- Streaming: 8 consecutive valid_in samples with random data and modes, followed by 3 idle cycles. Required: 8 consecutive valid_out pulses starting at cycle 2, results matching the model, and output held stable during the idle cycles.
- Reset mid-stream: assert rst for 1 cycle while 2 samples are in flight. Required: those samples are never output, valid_out=0, salida_total=12'h800, sat=0. The next sample appears exactly 2 cycles after its valid_in.
- SAT_COUNT_EN:
  - Feed 5 saturating samples and 3 non-saturating samples. Required: sat_count=5.
  - With SATCNT_W=2, feed 6 saturating samples. Required: sat_count=2'b11, held there with no wrap.
